// File: rtl/risc_pkg.sv
// Shared types and widths for the pipeline's memory-side blocks.
package risc_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_prio_starve.sv
// Two-requester priority pick: the high side wins until the low side has been
// passed over STARVE_MAX times while waiting, then the low side is forced through.
module arb_prio_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic hi_elig,
    input  logic lo_elig,
    input  logic lo_pending,
    output logic gnt_hi,
    output logic gnt_lo
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       hi_first;

    assign hi_first = hi_elig && (starve_cnt < STARVE_LIM);

    always_comb begin
        gnt_hi = 1'b0;
        gnt_lo = 1'b0;
        if (arb_en) begin
            if (hi_first) begin
                gnt_hi = 1'b1;
            end else if (lo_elig) begin
                gnt_lo = 1'b1;
            end else if (hi_elig) begin
                gnt_hi = 1'b1;
            end
        end
    end

    // Counts high-side wins taken while the low side was asking; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (gnt_lo) begin
            starve_cnt <= '0;
        end else if (gnt_hi && lo_pending && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and memory access,
// sequencing each access over a fixed read latency and raising per-stage stalls.
module mem_port_arbiter #(
    parameter int AW         = risc_pkg::AW,
    parameter int DW         = risc_pkg::DW,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          ma_req,
    input  logic          ma_we,
    input  logic [AW-1:0] ma_addr,
    input  logic [DW-1:0] ma_wdata,
    output logic [DW-1:0] ma_rdata,
    output logic          ma_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_ma,
    output logic          busy
);

    import risc_pkg::*;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    arb_state_t state;
    owner_t     owner;
    logic [2:0] wait_cnt;
    logic       arb_en;
    logic       if_elig;
    logic       ma_elig;
    logic       gnt_if;
    logic       gnt_ma;

    // A requester whose valid is pulsing this cycle is masked so it cannot re-win at once.
    assign if_elig  = if_req && !if_valid;
    assign ma_elig  = ma_req && !ma_valid;
    assign stall_if = if_req && !if_valid;
    assign stall_ma = ma_req && !ma_valid;
    assign arb_en   = (state == IDLE);

    arb_prio_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .arb_en    (arb_en),
        .hi_elig   (ma_elig),
        .lo_elig   (if_elig),
        .lo_pending(if_req),
        .gnt_hi    (gnt_ma),
        .gnt_lo    (gnt_if)
    );

    // The memory address/we/wdata registers double as the latched grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            wait_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ma_rdata  <= '0;
            if_valid  <= 1'b0;
            ma_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ma_valid <= 1'b0;
            mem_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_ma) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        owner     <= OWN_MA;
                        mem_addr  <= ma_addr;
                        mem_we    <= ma_we;
                        mem_wdata <= ma_wdata;
                    end else if (gnt_if) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        owner     <= OWN_IF;
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                    end
                end
                ISSUE: begin
                    if (MEM_LAT > 1) begin
                        state    <= WAIT;
                        wait_cnt <= 3'd1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAT_M1) begin
                        state    <= CAPTURE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (owner == OWN_MA) begin
                        ma_valid <= 1'b1;
                        // Stores still complete with a valid pulse but leave load data untouched.
                        if (!mem_we) begin
                            ma_rdata <= mem_rdata;
                        end
                    end else begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1/STARVE_MAX=2 and one at MEM_LAT=3,
// both driven by the same request stimulus, each with its own latency-matched memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        ma_req;
    logic        ma_we;
    logic [15:0] ma_addr;
    logic [15:0] ma_wdata;

    logic [15:0] if_rdata_1, ma_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        if_valid_1, ma_valid_1, mem_en_1, mem_we_1, stall_if_1, stall_ma_1, busy_1;
    logic [15:0] if_rdata_3, ma_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic        if_valid_3, ma_valid_3, mem_en_3, mem_we_3, stall_if_3, stall_ma_3, busy_3;

    logic [15:0] mem [0:1023];

    logic        rd1_vld = 1'b0;
    logic [15:0] rd1_dat = '0;
    logic [2:0]  rd3_vld = '0;
    logic [15:0] rd3_d0 = '0, rd3_d1 = '0, rd3_d2 = '0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(2)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1), .if_valid(if_valid_1),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata_1), .ma_valid(ma_valid_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .stall_if(stall_if_1), .stall_ma(stall_ma_1), .busy(busy_1)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_3), .if_valid(if_valid_3),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata_3), .ma_valid(ma_valid_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .stall_if(stall_if_3), .stall_ma(stall_ma_3), .busy(busy_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data appears MEM_LAT cycles after the strobe, poison otherwise.
    always @(posedge clk) begin
        rd1_vld <= mem_en_1;
        rd1_dat <= mem[mem_addr_1[9:0]];
        rd3_vld <= {rd3_vld[1:0], mem_en_3};
        rd3_d0  <= mem[mem_addr_3[9:0]];
        rd3_d1  <= rd3_d0;
        rd3_d2  <= rd3_d1;
    end
    assign mem_rdata_1 = rd1_vld    ? rd1_dat : 16'hDEAD;
    assign mem_rdata_3 = rd3_vld[2] ? rd3_d2  : 16'hDEAD;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic i_req, input logic [15:0] i_addr,
                                 input logic m_req, input logic m_we,
                                 input logic [15:0] m_addr, input logic [15:0] m_wdata);
        if_req   = i_req;
        if_addr  = i_addr;
        ma_req   = m_req;
        ma_we    = m_we;
        ma_addr  = m_addr;
        ma_wdata = m_wdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        mem[10'h010] = 16'hABCD;
        mem[10'h011] = 16'hC0DE;
        mem[10'h020] = 16'h5A5A;
        mem[10'h030] = 16'h3333;
        mem[10'h100] = 16'h1111;

        reset = 1'b1;
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        repeat (2) nextCycle();
        checkOutput("rst_ctl_1", {mem_en_1, mem_we_1, if_valid_1, ma_valid_1, busy_1, stall_if_1, stall_ma_1}, 0);
        checkOutput("rst_bus_1", {mem_addr_1, mem_wdata_1, if_rdata_1, ma_rdata_1}, 0);
        checkOutput("rst_ctl_3", {mem_en_3, mem_we_3, if_valid_3, ma_valid_3, busy_3, stall_if_3, stall_ma_3}, 0);
        checkOutput("rst_bus_3", {mem_addr_3, mem_wdata_3, if_rdata_3, ma_rdata_3}, 0);
        nextCycle();
        reset = 1'b0;

        $display("[TB] lone IF read");
        nextCycle();                                           // T
        applyStimulus(1, 16'h0010, 0, 0, 16'h0, 16'h0);
        checkOutput("if_stall_T", {stall_if_1, busy_1, mem_en_1}, 3'b100);
        nextCycle();                                           // T+1
        checkOutput("if_issue_1", {mem_en_1, mem_we_1, busy_1}, 3'b101);
        checkOutput("if_addr_1", mem_addr_1, 16'h0010);
        checkOutput("if_issue_3", {mem_en_3, busy_3}, 2'b11);
        nextCycle();                                           // T+2
        checkOutput("if_T2_1", {mem_en_1, stall_if_1, if_valid_1}, 3'b010);
        checkOutput("if_T2_3", {mem_en_3, busy_3}, 2'b01);
        nextCycle();                                           // T+3
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("if_valid_1", {if_valid_1, busy_1, stall_if_1}, 3'b100);
        checkOutput("if_rdata_1", if_rdata_1, 16'hABCD);
        checkOutput("lat3_T3", {busy_3, if_valid_3}, 2'b10);
        nextCycle();                                           // T+4
        checkOutput("if_T4_1", {if_valid_1, mem_en_1}, 2'b00);
        checkOutput("lat3_T4", {busy_3, if_valid_3}, 2'b10);
        nextCycle();                                           // T+5
        checkOutput("lat3_valid", {if_valid_3, busy_3}, 2'b10);
        checkOutput("lat3_rdata", if_rdata_3, 16'hABCD);
        nextCycle();                                           // T+6
        checkOutput("lat3_T6", if_valid_3, 0);

        $display("[TB] MA store");
        nextCycle();                                           // U
        applyStimulus(0, 16'h0, 1, 1, 16'h0200, 16'h1234);
        checkOutput("st_stall", stall_ma_1, 1);
        nextCycle();                                           // U+1
        applyStimulus(0, 16'h0, 1, 1, 16'hFFFF, 16'hFFFF);
        checkOutput("st_issue", {mem_en_1, mem_we_1}, 2'b11);
        checkOutput("st_bus", {mem_addr_1, mem_wdata_1}, {16'h0200, 16'h1234});
        nextCycle();                                           // U+2
        checkOutput("st_U2", {mem_en_1, mem_addr_1}, {1'b0, 16'h0200});
        nextCycle();                                           // U+3
        checkOutput("st_valid", {ma_valid_1, stall_ma_1}, 2'b10);
        checkOutput("st_rdata", {ma_rdata_1, if_rdata_1}, {16'h0000, 16'hABCD});
        nextCycle();                                           // U+4
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("st_U4", {ma_valid_1, mem_en_1}, 2'b00);
        repeat (3) nextCycle();

        $display("[TB] contention");
        nextCycle();                                           // C
        applyStimulus(1, 16'h0011, 1, 0, 16'h0020, 16'h0);
        checkOutput("ct_stalls", {stall_if_1, stall_ma_1}, 2'b11);
        nextCycle();                                           // C+1
        checkOutput("ct_ma_issue", {mem_en_1, mem_we_1, mem_addr_1}, {2'b10, 16'h0020});
        nextCycle();                                           // C+2
        checkOutput("ct_C2", {mem_en_1, stall_if_1}, 2'b01);
        nextCycle();                                           // C+3
        applyStimulus(1, 16'h0011, 0, 1, 16'h0, 16'h0);
        checkOutput("ct_ma_valid", {ma_valid_1, if_valid_1, stall_if_1}, 3'b101);
        checkOutput("ct_ma_rdata", ma_rdata_1, 16'h5A5A);
        nextCycle();                                           // C+4
        checkOutput("ct_if_issue", {mem_en_1, mem_we_1, mem_addr_1}, {2'b10, 16'h0011});
        nextCycle();                                           // C+5
        checkOutput("ct_C5", {stall_if_1, if_valid_1}, 2'b10);
        nextCycle();                                           // C+6
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("ct_if_valid", if_valid_1, 1);
        checkOutput("ct_rdata", {if_rdata_1, ma_rdata_1}, {16'hC0DE, 16'h5A5A});
        repeat (6) nextCycle();

        $display("[TB] starvation");
        nextCycle();                                           // S
        applyStimulus(1, 16'h0030, 1, 0, 16'h0100, 16'h0);
        checkOutput("sv_cnt0", u_dut1.u_arb.starve_cnt, 0);
        nextCycle();                                           // S+1
        applyStimulus(0, 16'h0030, 1, 0, 16'h0100, 16'h0);
        checkOutput("sv_g1", {mem_en_1, mem_addr_1}, {1'b1, 16'h0100});
        checkOutput("sv_cnt1", u_dut1.u_arb.starve_cnt, 1);
        repeat (2) nextCycle();                                // S+3
        checkOutput("sv_v1", {ma_valid_1, ma_rdata_1}, {1'b1, 16'h1111});
        nextCycle();                                           // S+4
        applyStimulus(1, 16'h0030, 1, 0, 16'h0100, 16'h0);
        checkOutput("sv_S4", {busy_1, mem_en_1, stall_if_1}, 3'b001);
        nextCycle();                                           // S+5
        applyStimulus(0, 16'h0030, 1, 0, 16'h0100, 16'h0);
        checkOutput("sv_g2", {mem_en_1, mem_addr_1}, {1'b1, 16'h0100});
        checkOutput("sv_cnt2", u_dut1.u_arb.starve_cnt, 2);
        repeat (2) nextCycle();                                // S+7
        checkOutput("sv_v2", ma_valid_1, 1);
        nextCycle();                                           // S+8
        applyStimulus(1, 16'h0030, 1, 0, 16'h0100, 16'h0);
        checkOutput("sv_S8", {busy_1, mem_en_1}, 2'b00);
        nextCycle();                                           // S+9
        checkOutput("sv_g3_if", {mem_en_1, mem_we_1, mem_addr_1}, {2'b10, 16'h0030});
        checkOutput("sv_cnt_clr", u_dut1.u_arb.starve_cnt, 0);
        repeat (2) nextCycle();                                // S+11
        applyStimulus(0, 16'h0030, 1, 0, 16'h0100, 16'h0);
        checkOutput("sv_if_valid", {if_valid_1, if_rdata_1}, {1'b1, 16'h3333});
        nextCycle();                                           // S+12
        checkOutput("sv_g4", {mem_en_1, mem_addr_1}, {1'b1, 16'h0100});
        repeat (2) nextCycle();                                // S+14
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("sv_v4", ma_valid_1, 1);
        repeat (16) nextCycle();

        $display("[TB] reset mid-wait");
        nextCycle();                                           // R
        applyStimulus(1, 16'h0010, 0, 0, 16'h0, 16'h0);
        checkOutput("rw_stall", stall_if_3, 1);
        nextCycle();                                           // R+1
        checkOutput("rw_issue", {mem_en_3, busy_3}, 2'b11);
        nextCycle();                                           // R+2
        checkOutput("rw_wait", {busy_3, mem_en_3}, 2'b10);
        reset = 1'b1;
        #1;
        checkOutput("rw_rst_ctl", {mem_en_3, mem_we_3, if_valid_3, ma_valid_3, busy_3}, 0);
        checkOutput("rw_rst_bus", {mem_addr_3, mem_wdata_3, if_rdata_3, ma_rdata_3}, 0);
        checkOutput("rw_rst_stall", stall_if_3, 1);
        nextCycle();                                           // R+3
        checkOutput("rw_R3", {busy_3, if_valid_3}, 2'b00);
        nextCycle();                                           // R+4
        reset = 1'b0;
        #1;
        checkOutput("rw_R4", {mem_en_3, busy_3, if_valid_3}, 3'b000);
        nextCycle();                                           // R+5
        checkOutput("rw_reissue", {mem_en_3, mem_addr_3}, {1'b1, 16'h0010});
        repeat (3) nextCycle();                                // R+8
        checkOutput("rw_R8", {busy_3, if_valid_3}, 2'b10);
        nextCycle();                                           // R+9
        applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("rw_valid", {if_valid_3, if_rdata_3}, {1'b1, 16'hABCD});

        repeat (2) nextCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
